vga_tile_renderer: RTL and testbench

//  Parametrised VGA timing generator and tile renderer for the snake display.

---
 rtl/vga_tile_renderer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// VGA timing generator and tile renderer for the snake display, with double-buffered snake/food state.
// Optional feature: define VGA_HEAD_COLOR_EN to draw piece 0 in C_HEAD (otherwise it uses C_SNAKE).

module vga_tile_renderer #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_PULSE    = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_PULSE    = 2,
    parameter int          V_BP       = 29,
    parameter logic        H_POL      = 1'b0,
    parameter logic        V_POL      = 1'b0,
    parameter int          BLOCK_W    = 40,
    parameter int          BLOCK_H    = 40,
    parameter int          X_BITS     = 4,
    parameter int          Y_BITS     = 4,
    parameter int          MAX_PIECES = 16,
    parameter logic [7:0]  C_EMPTY    = 8'h00,
    parameter logic [7:0]  C_WALL     = 8'hFF,
    parameter logic [7:0]  C_FOOD     = 8'hE0,
    parameter logic [7:0]  C_SNAKE    = 8'h1C,
`ifdef VGA_HEAD_COLOR_EN
    parameter logic [7:0]  C_HEAD     = 8'h03,
`endif
    localparam int         IDX_BITS   = $clog2(MAX_PIECES),
    localparam int         LEN_BITS   = IDX_BITS + 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                PieceWrEn,
    input  logic [IDX_BITS-1:0] PieceWrIdx,
    input  logic [X_BITS-1:0]   PieceWrX,
    input  logic [Y_BITS-1:0]   PieceWrY,
    input  logic [LEN_BITS-1:0] Length,
    input  logic [X_BITS-1:0]   FoodX,
    input  logic [Y_BITS-1:0]   FoodY,
    input  logic                Commit,
    output logic                Pending,
    output logic                FrameStart,
    output logic [7:0]          RGB,
    output logic                HSync,
    output logic                VSync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
    localparam int H_BITS  = $clog2(H_TOTAL);
    localparam int V_BITS  = $clog2(V_TOTAL);
    localparam int XS_BITS = $clog2(BLOCK_W);
    localparam int YS_BITS = $clog2(BLOCK_H);
    localparam int GRID_W  = H_ACTIVE / BLOCK_W;
    localparam int GRID_H  = V_ACTIVE / BLOCK_H;

    localparam logic [H_BITS-1:0]   H_LAST    = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0]   H_ACT_END = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0]   HS_START  = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0]   HS_END    = H_BITS'(H_ACTIVE + H_FP + H_PULSE);
    localparam logic [V_BITS-1:0]   V_LAST    = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0]   V_ACT_END = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0]   VS_START  = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0]   VS_END    = V_BITS'(V_ACTIVE + V_FP + V_PULSE);
    localparam logic [XS_BITS-1:0]  XS_LAST   = XS_BITS'(BLOCK_W - 1);
    localparam logic [YS_BITS-1:0]  YS_LAST   = YS_BITS'(BLOCK_H - 1);
    localparam logic [X_BITS-1:0]   X_MAX     = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]   Y_MAX     = Y_BITS'(GRID_H - 1);
    localparam logic [LEN_BITS-1:0] LEN_MAX   = LEN_BITS'(MAX_PIECES);

`ifdef VGA_HEAD_COLOR_EN
    localparam logic [7:0] HEAD_COLOUR = C_HEAD;
`else
    localparam logic [7:0] HEAD_COLOUR = C_SNAKE;
`endif

    logic [H_BITS-1:0]   h_cnt_q, h_cnt_d;
    logic [V_BITS-1:0]   v_cnt_q, v_cnt_d;
    logic [XS_BITS-1:0]  x_sub_q, x_sub_d;
    logic [YS_BITS-1:0]  y_sub_q, y_sub_d;
    logic [X_BITS-1:0]   x_blk_q, x_blk_d;
    logic [Y_BITS-1:0]   y_blk_q, y_blk_d;

    logic                s1_active_q, s1_active_d;
    logic [X_BITS-1:0]   s1_x_q, s1_x_d;
    logic [Y_BITS-1:0]   s1_y_q, s1_y_d;
    logic                s1_hs_q, s1_hs_d;
    logic                s1_vs_q, s1_vs_d;

    logic [7:0]          rgb_q, rgb_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;

    logic                pending_q, pending_d;
    logic [X_BITS-1:0]   sh_x_q  [MAX_PIECES];
    logic [X_BITS-1:0]   sh_x_d  [MAX_PIECES];
    logic [Y_BITS-1:0]   sh_y_q  [MAX_PIECES];
    logic [Y_BITS-1:0]   sh_y_d  [MAX_PIECES];
    logic [X_BITS-1:0]   act_x_q [MAX_PIECES];
    logic [X_BITS-1:0]   act_x_d [MAX_PIECES];
    logic [Y_BITS-1:0]   act_y_q [MAX_PIECES];
    logic [Y_BITS-1:0]   act_y_d [MAX_PIECES];
    logic [LEN_BITS-1:0] act_len_q, act_len_d;
    logic [X_BITS-1:0]   food_x_q, food_x_d;
    logic [Y_BITS-1:0]   food_y_q, food_y_d;

    logic                swap_point;
    logic                is_wall, is_food, is_head, is_body;

    // Block indices follow the raster incrementally so no divider is needed.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        x_sub_d = x_sub_q;
        y_sub_d = y_sub_q;
        x_blk_d = x_blk_q;
        y_blk_d = y_blk_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            x_sub_d = '0;
            x_blk_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
                y_sub_d = '0;
                y_blk_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + V_BITS'(1);
                if (y_sub_q == YS_LAST) begin
                    y_sub_d = '0;
                    y_blk_d = y_blk_q + Y_BITS'(1);
                end else begin
                    y_sub_d = y_sub_q + YS_BITS'(1);
                end
            end
        end else begin
            h_cnt_d = h_cnt_q + H_BITS'(1);
            if (x_sub_q == XS_LAST) begin
                x_sub_d = '0;
                x_blk_d = x_blk_q + X_BITS'(1);
            end else begin
                x_sub_d = x_sub_q + XS_BITS'(1);
            end
        end
    end

    always_comb begin
        s1_active_d = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        s1_x_d      = x_blk_q;
        s1_y_d      = y_blk_q;
        s1_hs_d     = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? H_POL : ~H_POL;
        s1_vs_d     = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? V_POL : ~V_POL;
    end

    assign swap_point = (h_cnt_q == '0) && (v_cnt_q == V_ACT_END);

    // Shadow buffer is frozen while a swap is pending; the swap lands on the first blank line.
    always_comb begin
        pending_d = pending_q;
        sh_x_d    = sh_x_q;
        sh_y_d    = sh_y_q;
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        act_len_d = act_len_q;
        food_x_d  = food_x_q;
        food_y_d  = food_y_q;
        if (PieceWrEn && !pending_q) begin
            sh_x_d[PieceWrIdx] = PieceWrX;
            sh_y_d[PieceWrIdx] = PieceWrY;
        end
        if (pending_q) begin
            if (swap_point) begin
                pending_d = 1'b0;
                act_x_d   = sh_x_q;
                act_y_d   = sh_y_q;
                act_len_d = (Length > LEN_MAX) ? LEN_MAX : Length;
                food_x_d  = FoodX;
                food_y_d  = FoodY;
            end
        end else if (Commit) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        is_wall = (s1_x_q == '0) || (s1_x_q == X_MAX) || (s1_y_q == '0) || (s1_y_q == Y_MAX);
        is_food = (s1_x_q == food_x_q) && (s1_y_q == food_y_q);
        is_head = (act_len_q != '0) && (act_x_q[0] == s1_x_q) && (act_y_q[0] == s1_y_q);
        is_body = 1'b0;
        for (int i = 1; i < MAX_PIECES; i++) begin
            if ((LEN_BITS'(i) < act_len_q) && (act_x_q[i] == s1_x_q) && (act_y_q[i] == s1_y_q)) begin
                is_body = 1'b1;
            end
        end
        rgb_d = 8'h00;
        if (s1_active_q) begin
            if (is_wall)      rgb_d = C_WALL;
            else if (is_food) rgb_d = C_FOOD;
            else if (is_head) rgb_d = HEAD_COLOUR;
            else if (is_body) rgb_d = C_SNAKE;
            else              rgb_d = C_EMPTY;
        end
        hsync_d = s1_hs_q;
        vsync_d = s1_vs_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            x_sub_q     <= '0;
            y_sub_q     <= '0;
            x_blk_q     <= '0;
            y_blk_q     <= '0;
            s1_active_q <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_hs_q     <= ~H_POL;
            s1_vs_q     <= ~V_POL;
            rgb_q       <= 8'h00;
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            pending_q   <= 1'b0;
            act_len_q   <= '0;
            food_x_q    <= '0;
            food_y_q    <= '0;
            for (int i = 0; i < MAX_PIECES; i++) begin
                sh_x_q[i]  <= '0;
                sh_y_q[i]  <= '0;
                act_x_q[i] <= '0;
                act_y_q[i] <= '0;
            end
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            x_sub_q     <= x_sub_d;
            y_sub_q     <= y_sub_d;
            x_blk_q     <= x_blk_d;
            y_blk_q     <= y_blk_d;
            s1_active_q <= s1_active_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            pending_q   <= pending_d;
            act_len_q   <= act_len_d;
            food_x_q    <= food_x_d;
            food_y_q    <= food_y_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
        end
    end

    assign Pending    = pending_q;
    assign FrameStart = swap_point && pending_q;
    assign RGB        = rgb_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer on a reduced raster (80 x 55, 4x4 blocks, 16 x 12 grid).
// Every cycle's outputs are compared against a pixel-coordinate model of the display.

module tb_vga_tile_renderer;

    localparam int HA = 64, HFP = 4, HP = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VP = 2, VBP = 3;
    localparam int HT = HA + HFP + HP + HBP;
    localparam int VT = VA + VFP + VP + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW = 4, BH = 4;
    localparam int GW = HA / BW, GH = VA / BH;
    localparam int SWAP_POS = VA * HT;
    localparam int NP = 16;

    localparam logic [7:0] C_EMPTY = 8'h00, C_WALL = 8'hFF, C_FOOD = 8'hE0, C_SNAKE = 8'h1C;
`ifdef VGA_HEAD_COLOR_EN
    localparam logic [7:0] HEAD_C = 8'h03;
`else
    localparam logic [7:0] HEAD_C = 8'h1C;
`endif

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       PieceWrEn = 1'b0;
    logic [3:0] PieceWrIdx = '0;
    logic [3:0] PieceWrX = '0;
    logic [3:0] PieceWrY = '0;
    logic [4:0] Length = '0;
    logic [3:0] FoodX = '0;
    logic [3:0] FoodY = '0;
    logic       Commit = 1'b0;
    logic       Pending, FrameStart, HSync, VSync;
    logic [7:0] RGB;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model state: shadow/active snake, food, pending flag.
    int m_sh_x[NP], m_sh_y[NP], m_act_x[NP], m_act_y[NP];
    int m_len, m_fx, m_fy;
    bit m_pending;

    vga_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_PULSE(HP), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_PULSE(VP), .V_BP(VBP),
        .BLOCK_W(BW), .BLOCK_H(BH)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .PieceWrEn(PieceWrEn), .PieceWrIdx(PieceWrIdx), .PieceWrX(PieceWrX), .PieceWrY(PieceWrY),
        .Length(Length), .FoodX(FoodX), .FoodY(FoodY), .Commit(Commit),
        .Pending(Pending), .FrameStart(FrameStart), .RGB(RGB), .HSync(HSync), .VSync(VSync)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] model_rgb(input int pos);
        int h, v, bx, by;
        h = pos % HT;
        v = pos / HT;
        if (h >= HA || v >= VA) return 8'h00;
        bx = h / BW;
        by = v / BH;
        if (bx == 0 || bx == GW - 1 || by == 0 || by == GH - 1) return C_WALL;
        if (bx == m_fx && by == m_fy) return C_FOOD;
        if (m_len > 0 && m_act_x[0] == bx && m_act_y[0] == by) return HEAD_C;
        for (int i = 1; i < m_len; i++)
            if (m_act_x[i] == bx && m_act_y[i] == by) return C_SNAKE;
        return C_EMPTY;
    endfunction

    function automatic logic model_hs(input int pos);
        int h;
        h = pos % HT;
        return (h >= HA + HFP && h < HA + HFP + HP) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic model_vs(input int pos);
        int v;
        v = pos / HT;
        return (v >= VA + VFP && v < VA + VFP + VP) ? 1'b0 : 1'b1;
    endfunction

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0;
        end
        m_len = 0; m_fx = 0; m_fy = 0; m_pending = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rgb"}, RGB, 8'h00);
        check_output({tag, "_hs"}, {7'd0, HSync}, 8'h01);
        check_output({tag, "_vs"}, {7'd0, VSync}, 8'h01);
        check_output({tag, "_pend"}, {7'd0, Pending}, 8'h00);
        check_output({tag, "_fs"}, {7'd0, FrameStart}, 8'h00);
    endtask

    // One clock: update the model for the coming edge, then compare after it.
    task automatic tick();
        int p, q;
        logic [7:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        p = cyc % FRAME;
        q = (p + FRAME - 1) % FRAME;
        e_rgb = model_rgb(q);
        e_hs  = model_hs(q);
        e_vs  = model_vs(q);
        if (PieceWrEn && !m_pending) begin
            m_sh_x[PieceWrIdx] = int'(PieceWrX);
            m_sh_y[PieceWrIdx] = int'(PieceWrY);
        end
        if (m_pending) begin
            if (p == SWAP_POS) begin
                for (int i = 0; i < NP; i++) begin
                    m_act_x[i] = m_sh_x[i];
                    m_act_y[i] = m_sh_y[i];
                end
                m_len = (int'(Length) > NP) ? NP : int'(Length);
                m_fx = int'(FoodX);
                m_fy = int'(FoodY);
                m_pending = 1'b0;
            end
        end else if (Commit) begin
            m_pending = 1'b1;
        end
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
        e_fs = ((cyc % FRAME) == SWAP_POS) && m_pending;
        check_output("rgb", RGB, e_rgb);
        check_output("hsync", {7'd0, HSync}, {7'd0, e_hs});
        check_output("vsync", {7'd0, VSync}, {7'd0, e_vs});
        check_output("pending", {7'd0, Pending}, {7'd0, m_pending});
        check_output("framestart", {7'd0, FrameStart}, {7'd0, e_fs});
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the output shows pixel (h,v); bounded to two frames.
    task automatic run_to(input int h, input int v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (cyc >= 2 && ((cyc + FRAME - 2) % FRAME) == v * HT + h) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("[TB] FAIL run_to(%0d,%0d): observed=timeout expected=reached", h, v);
        end
    endtask

    task automatic run_to_block(input int bx, input int by);
        run_to(bx * BW, by * BH);
    endtask

    task automatic wait_swap();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (!m_pending) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("[TB] FAIL wait_swap: observed=timeout expected=swap");
        end
    endtask

    task automatic apply_stimulus_write(input int idx, input int x, input int y);
        PieceWrEn  = 1'b1;
        PieceWrIdx = 4'(idx);
        PieceWrX   = 4'(x);
        PieceWrY   = 4'(y);
        tick();
        PieceWrEn  = 1'b0;
    endtask

    task automatic apply_stimulus_commit();
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge Clock);
        check_reset_outputs("reset");
        Reset_n = 1'b1;

        // Idle frames: walls, empty field, sync timing, first active pixel.
        run_to(0, 0);
        check_output("first_pixel_wall", RGB, C_WALL);
        run_to(HA, 0);
        check_output("hblank_black", RGB, 8'h00);
        run_to(HA + HFP - 1, 0);
        check_output("hs_before_pulse", {7'd0, HSync}, 8'h01);
        run_to(HA + HFP, 0);
        check_output("hs_pulse_start", {7'd0, HSync}, 8'h00);
        run_cycles(2 * FRAME);

        // Head, length 1, food.
        apply_stimulus_write(0, 5, 5);
        Length = 5'd1; FoodX = 4'd8; FoodY = 4'd3;
        apply_stimulus_commit();
        check_output("pending_after_commit", {7'd0, Pending}, 8'h01);
        wait_swap();
        run_to_block(8, 3);
        check_output("food_pixel", RGB, C_FOOD);
        run_to_block(5, 5);
        check_output("head_first_px", RGB, HEAD_C);
        run_to(5 * BW + BW - 1, 5 * BH + BH - 1);
        check_output("head_last_px", RGB, HEAD_C);

        // Writes and second commit while pending are dropped.
        Length = 5'd2;
        apply_stimulus_commit();
        apply_stimulus_write(1, 6, 5);
        apply_stimulus_commit();
        wait_swap();
        run_to_block(5, 5);
        check_output("head_kept", RGB, HEAD_C);
        run_to_block(6, 5);
        check_output("dropped_write_empty", RGB, C_EMPTY);

        // Length above capacity clamps to all 16 pieces.
        for (int i = 0; i < NP; i++) apply_stimulus_write(i, 1 + (i % 14), 7 + (i / 14));
        Length = 5'd20;
        apply_stimulus_commit();
        wait_swap();
        run_to_block(1, 7);
        check_output("clamp_head", RGB, HEAD_C);
        run_to_block(14, 7);
        check_output("clamp_piece13", RGB, C_SNAKE);
        run_to_block(2, 8);
        check_output("clamp_piece15", RGB, C_SNAKE);
        run_to_block(3, 8);
        check_output("clamp_beyond", RGB, C_EMPTY);

        // Priority: food over head, wall over body.
        apply_stimulus_write(0, 4, 4);
        apply_stimulus_write(3, 0, 7);
        FoodX = 4'd4; FoodY = 4'd4;
        apply_stimulus_commit();
        wait_swap();
        run_to_block(4, 4);
        check_output("food_over_head", RGB, C_FOOD);
        run_to_block(0, 7);
        check_output("wall_over_body", RGB, C_WALL);

        // Mid-line asynchronous reset.
        apply_stimulus_commit();
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((cyc % FRAME) == 10 * HT + 30) break;
            tick();
        end
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        check_reset_outputs("midline_held");
        Reset_n = 1'b1;
        run_to(0, 0);
        check_output("restart_wall", RGB, C_WALL);
        run_cycles(FRAME);

        // Randomised game-logic traffic.
        for (int i = 0; i < 3 * FRAME; i++) begin
            PieceWrEn  = ($urandom_range(0, 7) == 0);
            PieceWrIdx = 4'($urandom_range(0, 15));
            PieceWrX   = 4'($urandom_range(0, 15));
            PieceWrY   = 4'($urandom_range(0, 11));
            Commit     = ($urandom_range(0, 299) == 0);
            Length     = 5'($urandom_range(0, 31));
            FoodX      = 4'($urandom_range(0, 15));
            FoodY      = 4'($urandom_range(0, 11));
            tick();
        end
        PieceWrEn = 1'b0;
        Commit = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
